// File: rtl/imm_pipe_stage.sv
// imm_pipe_stage: RISC-V immediate decode into a SKID_DEPTH-entry FIFO stage.
// Define IMM_TARGET_EN to add the out_pc + out_imm target adder; otherwise out_target is 0.
module imm_pipe_stage #(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target
);
    localparam logic [1:0] DEPTH = 2'(SKID_DEPTH);
    localparam logic       LAST  = 1'(SKID_DEPTH - 1);

    logic [XLEN-1:0] r_imm  [SKID_DEPTH];
    logic [2:0]      r_type [SKID_DEPTH];
    logic [XLEN-1:0] r_pc   [SKID_DEPTH];
    logic            r_wr, r_rd, r_en;
    logic [1:0]      r_cnt;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_type;
    logic            w_push, w_pop, w_valid;

    always_comb begin
        w_type  = 3'd0;
        w_imm32 = '0;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_type  = 3'd1;
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                w_type  = 3'd2;
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                w_type  = 3'd3;
                w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_type  = 3'd4;
                w_imm32 = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                w_type  = 3'd5;
                w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_imm        = XLEN'(signed'(w_imm32));
    assign w_valid      = r_cnt != 2'd0;
    assign in_ready     = r_en && (r_cnt < DEPTH || out_ready);
    assign w_push       = in_valid && in_ready && !flush;
    assign w_pop        = w_valid && out_ready && !flush;
    assign out_valid    = w_valid;
    assign out_imm      = w_valid ? r_imm[r_rd] : '0;
    assign out_imm_type = w_valid ? r_type[r_rd] : 3'd0;
    assign out_pc       = w_valid ? r_pc[r_rd] : '0;
`ifdef IMM_TARGET_EN
    assign out_target   = out_pc + out_imm;
`else
    assign out_target   = '0;
`endif

    // r_en keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en  <= 1'b0;
            r_cnt <= 2'd0;
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            for (int k = 0; k < SKID_DEPTH; k++) begin
                r_imm[k]  <= '0;
                r_type[k] <= 3'd0;
                r_pc[k]   <= '0;
            end
        end else begin
            r_en <= 1'b1;
            if (flush) begin
                r_cnt <= 2'd0;
                r_wr  <= 1'b0;
                r_rd  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_imm[r_wr]  <= w_imm;
                    r_type[r_wr] <= w_type;
                    r_pc[r_wr]   <= in_pc;
                    r_wr         <= r_wr == LAST ? 1'b0 : r_wr + 1'b1;
                end
                if (w_pop)
                    r_rd <= r_rd == LAST ? 1'b0 : r_rd + 1'b1;
                r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end
endmodule
